// File: rtl/cronometro_ctrl_if.sv
// Command/status bundle between the stopwatch control sequencer and its environment.
// The master side drives buttons and recall switches; the slave side is the sequencer.
interface cronometro_ctrl_if;
  logic       key_start_n;
  logic       key_clear_n;
  logic       key_lap_n;
  logic [2:0] sw_recall;
  logic       tick;
  logic       cnt_clear;
  logic       lap_we;
  logic [1:0] lap_slot;
  logic       cnt_load;
  logic [1:0] load_slot;
  logic       cnt_restore;
  logic       running;
  logic [1:0] state_o;
  logic [1:0] lap_count;

  modport master (
    output key_start_n, key_clear_n, key_lap_n, sw_recall,
    input  tick, cnt_clear, lap_we, lap_slot, cnt_load, load_slot,
    input  cnt_restore, running, state_o, lap_count
  );

  modport slave (
    input  key_start_n, key_clear_n, key_lap_n, sw_recall,
    output tick, cnt_clear, lap_we, lap_slot, cnt_load, load_slot,
    output cnt_restore, running, state_o, lap_count
  );
endinterface

// File: rtl/cronometro_ctrl.sv
// Stopwatch control sequencer: key sync + press detection, IDLE/RUN/PAUSE/RECALL FSM,
// tick prescaler and lap pointer. Define DEBOUNCE_EN to add a per-key stability filter.
module cronometro_ctrl #(
  parameter int DIV        = 500000,
  parameter int LAP_SLOTS  = 3,
  parameter int DEB_CYCLES = 1000000
) (
  input logic              CLOCK_50,
  input logic              reset_n,
  cronometro_ctrl_if.slave bus
);
  localparam int         PW        = $clog2(DIV);
  localparam logic [1:0] LAST_SLOT = 2'(LAP_SLOTS - 1);
  localparam logic [1:0] MAX_COUNT = 2'(LAP_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_RECALL = 2'd3
  } state_e;

  // Lowest set bit wins; callers only use the result when the input is nonzero.
  function automatic logic [1:0] sel_index(input logic [2:0] v);
    logic [1:0] idx;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else begin
      idx = 2'd2;
    end
    return idx;
  endfunction

  // Key vectors are ordered {lap, clear, start}.
  logic [2:0] key_pin_s;
  logic [2:0] key_s1_q, key_s2_q, key_lvl_s, key_prev_q, key_ev_q;
  logic [2:0] sw_s1_q, sw_s2_q;

  assign key_pin_s = {bus.key_lap_n, bus.key_clear_n, bus.key_start_n};

  // Two-flop synchronizers: keys idle released (high), switches idle at zero.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      key_s1_q <= 3'b111;
      key_s2_q <= 3'b111;
      sw_s1_q  <= 3'b000;
      sw_s2_q  <= 3'b000;
    end else begin
      key_s1_q <= key_pin_s;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= bus.sw_recall;
      sw_s2_q  <= sw_s1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic [2:0]         filt_q;
  logic [2:0][DW-1:0] deb_cnt_q;

  // A key level is accepted only after DEB_CYCLES consecutive cycles at the new value.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      filt_q    <= 3'b111;
      deb_cnt_q <= {(3 * DW){1'b0}};
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (key_s2_q[k] != filt_q[k]) begin
          if (deb_cnt_q[k] == DW'(DEB_CYCLES - 1)) begin
            filt_q[k]    <= key_s2_q[k];
            deb_cnt_q[k] <= {DW{1'b0}};
          end else begin
            deb_cnt_q[k] <= deb_cnt_q[k] + DW'(1);
          end
        end else begin
          deb_cnt_q[k] <= {DW{1'b0}};
        end
      end
    end
  end

  assign key_lvl_s = filt_q;
`else
  assign key_lvl_s = key_s2_q;
`endif

  // Registered falling-edge detector: one event per press however long it is held.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      key_prev_q <= 3'b111;
      key_ev_q   <= 3'b000;
    end else begin
      key_prev_q <= key_lvl_s;
      key_ev_q   <= key_prev_q & ~key_lvl_s;
    end
  end

  logic       ev_clear_s, ev_start_s, ev_lap_s;
  logic [1:0] sel_idx_s;
  logic       sel_valid_s;

  state_e         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           tick_q, tick_d;
  logic           clr_q, clr_d;
  logic           lap_we_q, lap_we_d;
  logic [1:0]     lap_slot_q, lap_slot_d;
  logic [1:0]     lap_count_q, lap_count_d;
  logic           load_q, load_d;
  logic [1:0]     load_slot_q, load_slot_d;
  logic           restore_q, restore_d;
  logic           running_q;

  assign ev_clear_s  = key_ev_q[1];
  assign ev_start_s  = key_ev_q[0] & ~key_ev_q[1];
  assign ev_lap_s    = key_ev_q[2] & ~key_ev_q[1] & ~key_ev_q[0];
  assign sel_idx_s   = sel_index(sw_s2_q);
  assign sel_valid_s = (sw_s2_q != 3'b000) && (sel_idx_s < lap_count_q);

  // Next-state and command-pulse decode; clear overrides every state.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    tick_d      = 1'b0;
    clr_d       = 1'b0;
    lap_we_d    = 1'b0;
    load_d      = 1'b0;
    restore_d   = 1'b0;
    load_slot_d = load_slot_q;
    lap_slot_d  = lap_slot_q;
    lap_count_d = lap_count_q;

    // The pointer moves the cycle after lap_we so the datapath sees the slot being written.
    if (lap_we_q) begin
      lap_slot_d  = (lap_slot_q == LAST_SLOT) ? 2'd0 : lap_slot_q + 2'd1;
      lap_count_d = (lap_count_q == MAX_COUNT) ? MAX_COUNT : lap_count_q + 2'd1;
    end else begin
      lap_slot_d  = lap_slot_q;
      lap_count_d = lap_count_q;
    end

    if (ev_clear_s) begin
      clr_d       = 1'b1;
      state_d     = ST_IDLE;
      presc_d     = {PW{1'b0}};
      lap_slot_d  = 2'd0;
      lap_count_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ev_start_s) begin
            state_d = ST_RUN;
            presc_d = {PW{1'b0}};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (ev_start_s) begin
            state_d = ST_PAUSE;
          end else begin
            if (presc_q == PW'(DIV - 1)) begin
              presc_d = {PW{1'b0}};
              tick_d  = 1'b1;
            end else begin
              presc_d = presc_q + PW'(1);
            end
            lap_we_d = ev_lap_s;
          end
        end
        ST_PAUSE: begin
          if (ev_start_s) begin
            state_d = ST_RUN;
          end else if (sel_valid_s) begin
            load_d      = 1'b1;
            load_slot_d = sel_idx_s;
            state_d     = ST_RECALL;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_RECALL: begin
          if (ev_start_s) begin
            restore_d = 1'b1;
            state_d   = ST_RUN;
          end else if (sw_s2_q == 3'b000) begin
            restore_d = 1'b1;
            state_d   = ST_PAUSE;
          end else if (sel_valid_s && (sel_idx_s != load_slot_q)) begin
            load_d      = 1'b1;
            load_slot_d = sel_idx_s;
          end else begin
            state_d = ST_RECALL;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, prescaler, pointers and registered command outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      presc_q     <= {PW{1'b0}};
      tick_q      <= 1'b0;
      clr_q       <= 1'b0;
      lap_we_q    <= 1'b0;
      lap_slot_q  <= 2'd0;
      lap_count_q <= 2'd0;
      load_q      <= 1'b0;
      load_slot_q <= 2'd0;
      restore_q   <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      clr_q       <= clr_d;
      lap_we_q    <= lap_we_d;
      lap_slot_q  <= lap_slot_d;
      lap_count_q <= lap_count_d;
      load_q      <= load_d;
      load_slot_q <= load_slot_d;
      restore_q   <= restore_d;
      running_q   <= (state_d == ST_RUN);
    end
  end

  assign bus.tick        = tick_q;
  assign bus.cnt_clear   = clr_q;
  assign bus.lap_we      = lap_we_q;
  assign bus.lap_slot    = lap_slot_q;
  assign bus.cnt_load    = load_q;
  assign bus.load_slot   = load_slot_q;
  assign bus.cnt_restore = restore_q;
  assign bus.running     = running_q;
  assign bus.state_o     = state_q;
  assign bus.lap_count   = lap_count_q;
endmodule

// File: tb/tb_cronometro_ctrl.sv
// Scoreboard bench for cronometro_ctrl with DIV=4: expected command pulses are queued
// when a press or switch change is driven and matched by a monitor on the falling edge.
module tb_cronometro_ctrl;
  localparam int DIV = 4;

  typedef struct {
    int c;
    int slot;
  } exp_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  int    cyc     = 0;
  int    n_total = 0;
  int    n_bad   = 0;
  int    run_cnt = 0;
  exp_t  q_tick[$];
  exp_t  q_lap[$];
  exp_t  q_load[$];
  exp_t  q_rest[$];
  exp_t  q_clr[$];
  string kind_name[5] = '{"tick", "lap_we", "cnt_load", "cnt_restore", "cnt_clear"};

  cronometro_ctrl_if bus ();

  cronometro_ctrl #(
    .DIV        (DIV),
    .LAP_SLOTS  (3),
    .DEB_CYCLES (8)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int slot);
    exp_t e;
    e.c = c;
    e.slot = slot;
    case (kind)
      0: q_tick.push_back(e);
      1: q_lap.push_back(e);
      2: q_load.push_back(e);
      3: q_rest.push_back(e);
      default: q_clr.push_back(e);
    endcase
  endtask

  // Expected ticks for RUN cycles strictly between entry edge a and leaving edge b.
  task automatic push_ticks(input int a, input int b);
    for (int t = a + 1; t < b; t++) begin
      run_cnt++;
      if (run_cnt % DIV == 0) push(0, t, 0);
    end
  endtask

  task automatic see(input int kind, input int slot);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (kind)
      0: if (q_tick.size() > 0) begin e = q_tick.pop_front(); have = 1'b1; end
      1: if (q_lap.size() > 0)  begin e = q_lap.pop_front();  have = 1'b1; end
      2: if (q_load.size() > 0) begin e = q_load.pop_front(); have = 1'b1; end
      3: if (q_rest.size() > 0) begin e = q_rest.pop_front(); have = 1'b1; end
      default: if (q_clr.size() > 0) begin e = q_clr.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      chk({kind_name[kind], "_unexpected"}, 32'd1, 32'd0);
    end else begin
      chk({kind_name[kind], "_cycle"}, cyc, e.c);
      if (kind == 1 || kind == 2) chk({kind_name[kind], "_slot"}, slot, e.slot);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tick)        see(0, 0);
      if (bus.lap_we)      see(1, int'(bus.lap_slot));
      if (bus.cnt_load)    see(2, int'(bus.load_slot));
      if (bus.cnt_restore) see(3, 0);
      if (bus.cnt_clear)   see(4, 0);
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // keys: bit0 start, bit1 clear, bit2 lap; held low for 3 cycles.
  task automatic press(input logic [2:0] keys);
    int c0;
    c0 = cyc;
    if (keys[0]) bus.key_start_n = 1'b0;
    if (keys[1]) bus.key_clear_n = 1'b0;
    if (keys[2]) bus.key_lap_n   = 1'b0;
    wait_to(c0 + 3);
    bus.key_start_n = 1'b1;
    bus.key_clear_n = 1'b1;
    bus.key_lap_n   = 1'b1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_state"},     bus.state_o,     32'd0);
    chk({pfx, "_running"},   bus.running,     32'd0);
    chk({pfx, "_tick"},      bus.tick,        32'd0);
    chk({pfx, "_clear"},     bus.cnt_clear,   32'd0);
    chk({pfx, "_lap_we"},    bus.lap_we,      32'd0);
    chk({pfx, "_lap_slot"},  bus.lap_slot,    32'd0);
    chk({pfx, "_load"},      bus.cnt_load,    32'd0);
    chk({pfx, "_load_slot"}, bus.load_slot,   32'd0);
    chk({pfx, "_restore"},   bus.cnt_restore, 32'd0);
    chk({pfx, "_lap_count"}, bus.lap_count,   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int c, e, p, r, k, rr;
    bus.key_start_n = 1'b1;
    bus.key_clear_n = 1'b1;
    bus.key_lap_n   = 1'b1;
    bus.sw_recall   = 3'b000;
    #12;
    chk_all_zero("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_to(3);

`ifdef DEBOUNCE_EN
    // A 5-cycle glitch must be filtered out.
    c = cyc;
    bus.key_start_n = 1'b0;
    wait_to(c + 5);
    bus.key_start_n = 1'b1;
    wait_to(c + 30);
    chk("deb_glitch_state", bus.state_o, 32'd0);
    // A 12-cycle hold gives one event 11 cycles after the fall, command 1 cycle later.
    c = cyc;
    e = c + 12;
    push_ticks(e, e + 6);
    bus.key_start_n = 1'b0;
    wait_to(c + 11);
    chk("deb_before_state", bus.state_o, 32'd0);
    wait_to(c + 12);
    chk("deb_after_state", bus.state_o, 32'd1);
    bus.key_start_n = 1'b1;
    wait_to(e + 5);
`else
    // Run, 5 ticks, pause with prescaler at 1.
    c = cyc;
    e = c + 4;
    push_ticks(e, e + 22);
    press(3'b001);
    wait_to(e + 1);
    chk("run_state", bus.state_o, 32'd1);
    chk("run_running", bus.running, 32'd1);
    wait_to(e + 18);
    press(3'b001);
    p = e + 22;
    wait_to(p + 1);
    chk("pause_state", bus.state_o, 32'd2);
    chk("pause_running", bus.running, 32'd0);
    wait_to(p + 24);

    // Resume and take 4 laps, two of them on tick cycles.
    c = cyc;
    r = c + 4;
    push_ticks(r, r + 32);
    push(1, r + 7, 0);
    push(1, r + 13, 1);
    push(1, r + 19, 2);
    push(1, r + 25, 0);
    press(3'b001);
    wait_to(r + 3);
    press(3'b100);
    wait_to(r + 9);
    chk("lap_count_1", bus.lap_count, 32'd1);
    press(3'b100);
    wait_to(r + 15);
    chk("lap_count_2", bus.lap_count, 32'd2);
    press(3'b100);
    wait_to(r + 21);
    chk("lap_count_3", bus.lap_count, 32'd3);
    press(3'b100);
    wait_to(r + 28);
    chk("lap_count_sat", bus.lap_count, 32'd3);
    chk("lap_slot_wrap", bus.lap_slot, 32'd1);
    // start + lap together: pause only.
    press(3'b101);
    wait_to(r + 33);
    chk("startlap_state", bus.state_o, 32'd2);

    // clear + start together in PAUSE.
    c = cyc;
    k = c + 4;
    push(4, k, 0);
    press(3'b011);
    wait_to(k + 1);
    chk("clr_state", bus.state_o, 32'd0);
    chk("clr_lap_count", bus.lap_count, 32'd0);
    chk("clr_lap_slot", bus.lap_slot, 32'd0);
    run_cnt = 0;

    // Two laps then pause.
    c = cyc;
    e = c + 4;
    push_ticks(e, e + 18);
    push(1, e + 6, 0);
    push(1, e + 12, 1);
    press(3'b001);
    wait_to(e + 2);
    press(3'b100);
    wait_to(e + 8);
    press(3'b100);
    wait_to(e + 14);
    press(3'b001);
    wait_to(e + 19);
    chk("p2_state", bus.state_o, 32'd2);
    chk("p2_lap_count", bus.lap_count, 32'd2);

    // Recall sequence.
    c = cyc;
    bus.sw_recall = 3'b100;
    wait_to(c + 8);
    chk("rc_invalid_state", bus.state_o, 32'd2);
    c = cyc;
    bus.sw_recall = 3'b010;
    push(2, c + 3, 1);
    wait_to(c + 4);
    chk("rc_state", bus.state_o, 32'd3);
    chk("rc_load_slot", bus.load_slot, 32'd1);
    c = cyc;
    bus.sw_recall = 3'b011;
    push(2, c + 3, 0);
    wait_to(c + 5);
    chk("rc_prio_slot", bus.load_slot, 32'd0);
    c = cyc;
    bus.sw_recall = 3'b100;
    wait_to(c + 6);
    chk("rc_inval_state", bus.state_o, 32'd3);
    c = cyc;
    bus.sw_recall = 3'b000;
    push(3, c + 3, 0);
    wait_to(c + 4);
    chk("rc_restore_state", bus.state_o, 32'd2);
    c = cyc;
    bus.sw_recall = 3'b001;
    push(2, c + 3, 0);
    wait_to(c + 5);
    chk("rc2_state", bus.state_o, 32'd3);
    // start from RECALL: restore and RUN, prescaler resumes from 1.
    c = cyc;
    rr = c + 4;
    push(3, rr, 0);
    push_ticks(rr, rr + 10);
    press(3'b001);
    bus.sw_recall = 3'b000;
    wait_to(rr + 1);
    chk("rc_run_state", bus.state_o, 32'd1);
    wait_to(rr + 9);
    chk("pre_rst_lap_count", bus.lap_count, 32'd2);
`endif

    // Asynchronous reset in the middle of RUN.
    chk("pre_rst_state", bus.state_o, 32'd1);
    chk("pre_rst_running", bus.running, 32'd1);
    rst_n = 1'b0;
    #2;
    chk_all_zero("async_rst");
    repeat (3) @(posedge clk);
    #1;
    chk("left_tick", q_tick.size(), 32'd0);
    chk("left_lap", q_lap.size(), 32'd0);
    chk("left_load", q_load.size(), 32'd0);
    chk("left_restore", q_rest.size(), 32'd0);
    chk("left_clear", q_clr.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
